// File: rtl/seq_mul_div.sv
// seq_mul_div: iterative signed 32x32 multiply / 32/32 divide unit.
//   Multiply: one shift-add step per cycle on operand magnitudes.
//   Divide:   one restoring shift-subtract step per cycle on magnitudes.
//   A final FIX cycle applies sign correction and registers the result.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset
//   start    in   request pulse, accepted only when idle (busy=0)
//   op       in   0 = signed multiply, 1 = signed divide
//   a        in   multiplicand / dividend
//   b        in   multiplier / divisor
//   busy     out  high from the cycle after acceptance through the done cycle
//   done     out  one-cycle pulse, result valid from this cycle
//   result   out  {product high, product low} or {remainder, quotient}
//   div_zero out  set with done when a divide had b = 0
module seq_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      op,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      busy,
    output logic                      done,
    output logic        [2*WIDTH-1:0] result,
    output logic                      div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 div_zero_q, div_zero_d;

    logic                 op_q, op_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;      // multiply accumulator
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;  // shifted multiplicand; low half holds divisor
    logic [WIDTH-1:0]     y_q, y_d;          // multiplier bits / dividend shifting into quotient
    logic [WIDTH:0]       rem_q, rem_d;      // partial remainder with borrow bit

    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       diff;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_mul(input logic [2*WIDTH-1:0] p, input logic neg);
        return neg ? (~p + (2*WIDTH)'(1)) : p;
    endfunction

    // Quotient truncates toward zero; remainder follows the dividend sign.
    function automatic logic [2*WIDTH-1:0] fix_div(input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] r,
                                                   input logic sa, input logic sb);
        logic [WIDTH-1:0] qs;
        logic [WIDTH-1:0] rs;
        qs = (sa ^ sb) ? (~q + WIDTH'(1)) : q;
        rs = sa ? (~r + WIDTH'(1)) : r;
        return {rs, qs};
    endfunction

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        dz_d       = dz_q;
        a_raw_d    = a_raw_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        y_d        = y_q;
        rem_d      = rem_q;

        rem_shift = {rem_q[WIDTH-1:0], y_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, mcand_q[WIDTH-1:0]};

        case (state_q)
            IDLE: begin
                // busy is still high in the done cycle, which blocks a start there.
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    op_d     = op;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
                    a_raw_d  = a;
                    acc_d    = '0;
                    rem_d    = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    dz_d     = op && (b == '0);
                    if (op) begin
                        y_d     = mag(a);
                        mcand_d = {{WIDTH{1'b0}}, mag(b)};
                    end else begin
                        y_d     = mag(b);
                        mcand_d = {{WIDTH{1'b0}}, mag(a)};
                    end
                    state_d = (op && (b == '0)) ? FIX : CALC;
                end
            end
            CALC: begin
                if (op_q) begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff;
                        y_d   = {y_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift;
                        y_d   = {y_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (y_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
                    y_d     = {1'b0, y_q[WIDTH-1:1]};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    result_d = {a_raw_q, {WIDTH{1'b1}}};
                end else if (op_q) begin
                    result_d = fix_div(y_q, rem_q[WIDTH-1:0], sign_a_q, sign_b_q);
                end else begin
                    result_d = fix_mul(acc_q, sign_a_q ^ sign_b_q);
                end
                div_zero_d = dz_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Operand and working registers need no reset: they are reloaded on every accepted start.
    always_ff @(posedge clock) begin
        op_q     <= op_d;
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
        dz_q     <= dz_d;
        a_raw_q  <= a_raw_d;
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        y_q      <= y_d;
        rem_q    <= rem_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Testbench for seq_mul_div: directed vector table plus hand-written
// sequences for start-while-busy, reset abort, div_zero hold and
// back-to-back operation.
module tb_seq_mul_div;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_zero;

    int vec_cnt    = 0;
    int miscompares = 0;
    int done_cnt   = 0;

    seq_mul_div #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic        dz;
        int          edges;
    } vec_t;

    vec_t tbl[13];

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Drives one start pulse; returns in the cycle after the accepting edge.
    task automatic launch(input logic o, input logic [31:0] aa, input logic [31:0] bb);
        op    = o;
        a     = aa;
        b     = bb;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(inout int edges);
        while (done !== 1'b1 && edges < 60) begin
            tick(1);
            edges++;
        end
    endtask

    initial begin
        int edges;
        int d0;

        tbl[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 34};
        tbl[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 34};
        tbl[2]  = '{1'b1, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 34};
        tbl[3]  = '{1'b1, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1, 2};
        tbl[4]  = '{1'b0, 32'd3,        32'd4,        64'h00000000_0000000C, 1'b0, 34};
        tbl[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34};
        tbl[6]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34};
        tbl[7]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 34};
        tbl[8]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0, 34};
        tbl[9]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1'b0, 34};
        tbl[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1'b0, 34};
        tbl[11] = '{1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 34};
        tbl[12] = '{1'b1, 32'd3,        32'd5,        64'h00000003_00000000, 1'b0, 34};

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        tick(2);
        chk("reset_busy",     64'(busy),     64'd0);
        chk("reset_done",     64'(done),     64'd0);
        chk("reset_result",   result,        64'd0);
        chk("reset_div_zero", 64'(div_zero), 64'd0);
        reset = 1'b0;
        tick(1);

        for (int i = 0; i < 13; i++) begin
            launch(tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("v%0d_busy_after_e0", i), 64'(busy), 64'd1);
            edges = 1;
            wait_done(edges);
            chk($sformatf("v%0d_latency", i),  64'(edges),    64'(tbl[i].edges));
            chk($sformatf("v%0d_result", i),   result,        tbl[i].res);
            chk($sformatf("v%0d_div_zero", i), 64'(div_zero), 64'(tbl[i].dz));
            chk($sformatf("v%0d_busy_in_done", i), 64'(busy), 64'd1);
            tick(1);
            chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
            chk($sformatf("v%0d_busy_after", i), 64'(busy), 64'd0);
        end

        // div_zero and result hold through the next operation until its done.
        launch(1'b1, 32'd5, 32'd0);
        edges = 1;
        wait_done(edges);
        chk("dz_latency", 64'(edges), 64'd2);
        tick(1);
        launch(1'b0, 32'd3, 32'd4);
        tick(10);
        chk("dz_hold_flag",   64'(div_zero), 64'd1);
        chk("dz_hold_result", result,        64'h00000005_FFFFFFFF);
        edges = 11;
        wait_done(edges);
        chk("dz_clear_latency", 64'(edges),    64'd34);
        chk("dz_clear_flag",    64'(div_zero), 64'd0);
        chk("dz_clear_result",  result,        64'h00000000_0000000C);
        tick(1);

        // start pulses during CALC (cycle 5) and during FIX are ignored.
        d0 = done_cnt;
        launch(1'b0, 32'd7, 32'hFFFFFFFD);
        tick(4);
        op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(27);
        op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("ign_done_cycle34", 64'(done), 64'd1);
        chk("ign_result",       result,    64'hFFFFFFFF_FFFFFFEB);
        tick(40);
        chk("ign_done_count", 64'(done_cnt - d0), 64'd1);
        chk("ign_busy_idle",  64'(busy),          64'd0);

        // Back-to-back: start in the cycle right after done.
        d0 = done_cnt;
        launch(1'b1, 32'd100, 32'd7);
        edges = 1;
        wait_done(edges);
        chk("b2b_first_result", result, 64'h00000002_0000000E);
        tick(1);
        launch(1'b0, 32'd7, 32'hFFFFFFFD);
        edges = 1;
        wait_done(edges);
        chk("b2b_second_latency", 64'(edges), 64'd34);
        chk("b2b_second_result",  result,     64'hFFFFFFFF_FFFFFFEB);
        tick(40);
        chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);

        // Reset in cycle 10 aborts the operation; start in that cycle is dropped.
        d0 = done_cnt;
        launch(1'b0, 32'd3, 32'd4);
        tick(9);
        reset = 1'b1;
        start = 1'b1;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_result",   result,        64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        tick(40);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_idle",    64'(busy),          64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
